// File: rtl/mem_stream_reader.sv
// Burst read client for a single-clock dual-port memory: issues credit-limited reads
// and streams the returned words through a 4-entry buffer. Optional: MEM_STREAM_READER_WRAP_EN.
module mem_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_mem_rd,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rddata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   issue_addr_q, issue_addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    issued_q, issued_d;
    logic [LEN_WIDTH-1:0]    dlv_q, dlv_d;
    logic                    pend_q;
    logic [DATA_WIDTH-1:0]   fifo_q [4];
    logic [1:0]              wr_ptr_q, rd_ptr_q;
    logic [2:0]              count_q, count_d;

    logic                    push, pop, issue, credit_ok, req_reject;
    logic [2:0]              in_flight;

    // Reject requests that would run past the top of memory unless wrapping is enabled.
`ifdef MEM_STREAM_READER_WRAP_EN
    assign req_reject = 1'b0;
`else
    logic [SUM_W-1:0] req_sum;
    assign req_sum    = SUM_W'(i_base_addr) + SUM_W'(i_len);
    assign req_reject = (req_sum > SUM_W'(DEPTH));
`endif

    assign o_valid   = (count_q != 3'd0);
    assign o_data    = fifo_q[rd_ptr_q];
    assign o_last    = o_valid && (dlv_q == len_q - LEN_WIDTH'(1));
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_mem_rd  = rd_q;
    assign o_mem_addr = addr_q;

    // A strobe occupies one stage in rd_q and one in pend_q before its data lands in the buffer.
    assign push      = pend_q;
    assign pop       = o_valid && i_ready;
    assign in_flight = {2'b00, rd_q} + {2'b00, pend_q};
    assign credit_ok = ((count_q + in_flight) < 3'd4);
    assign issue     = (state_q == RUN) && (issued_q != len_q) && credit_ok;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        rd_d         = issue;
        addr_d       = issue ? issue_addr_q : addr_q;
        issue_addr_d = issue ? issue_addr_q + ADDR_WIDTH'(1) : issue_addr_q;
        len_d        = len_q;
        issued_d     = issue ? issued_q + LEN_WIDTH'(1) : issued_q;
        dlv_d        = pop ? dlv_q + LEN_WIDTH'(1) : dlv_q;
        count_d      = count_q + {2'b00, push} - {2'b00, pop};
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else if (req_reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        busy_d       = 1'b1;
                        len_d        = i_len;
                        issue_addr_d = i_base_addr;
                        issued_d     = '0;
                        dlv_d        = '0;
                    end
                end
            end
            RUN: begin
                if (issue && (issued_q == len_q - LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && o_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            issue_addr_q <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            dlv_q        <= '0;
            pend_q       <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            issue_addr_q <= issue_addr_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            dlv_q        <= dlv_d;
            pend_q       <= rd_q;
            count_q      <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= i_mem_rddata;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural one-cycle-latency memory.
// Build with +define+MEM_STREAM_READER_WRAP_EN to check the wrapping variant.
module tb_mem_stream_reader;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [5:0] i_base_addr;
    logic [6:0] i_len;
    logic       o_busy, o_done, o_err, o_mem_rd;
    logic [5:0] o_mem_addr;
    logic [7:0] i_mem_rddata;
    logic       o_valid, i_ready, o_last;
    logic [7:0] o_data;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_model [64];
    logic [7:0] hs_data [$];
    logic       hs_last [$];
    logic [5:0] strb_addr [$];

    mem_stream_reader dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_rddata(i_mem_rddata),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_rd) i_mem_rddata <= mem_model[o_mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Log what the next edge will sample, then advance to the following negedge.
    task automatic tick();
        if (o_valid && i_ready) begin
            hs_data.push_back(o_data);
            hs_last.push_back(o_last);
            $display("xfer data=%02h last=%0d", o_data, o_last);
        end
        if (o_mem_rd) strb_addr.push_back(o_mem_addr);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic clear_logs();
        hs_data.delete();
        hs_last.delete();
        strb_addr.delete();
    endtask

    task automatic wait_done(input int max, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (o_done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_words(input string tag, input int base, input int n);
        chk({tag, "_count"}, 32'(hs_data.size()), 32'(n));
        for (int i = 0; i < n && i < hs_data.size(); i++) begin
            chk({tag, "_data"}, 32'(hs_data[i]), 32'(8'((base + i) % 64 + 8'h10)));
            chk({tag, "_last"}, 32'(hs_last[i]), 32'(i == n - 1));
        end
    endtask

    task automatic start_burst(input logic [5:0] base, input logic [6:0] len);
        i_base_addr = base;
        i_len       = len;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem_model[a] = 8'(a + 8'h10);
        i_mem_rddata = 8'h00;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = '0;
        i_len = '0;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_mem_rd", 32'(o_mem_rd), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_addr", 32'(o_mem_addr), 0);
        chk("rst_done_err_last", 32'({o_done, o_err, o_last}), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Burst base=4 len=5 with ready held high: latency and back-to-back delivery.
        clear_logs();
        start_burst(6'd4, 7'd5);
        chk("t1_busy", 32'(o_busy), 1);
        chk("t1_rd_k0", 32'(o_mem_rd), 0);
        tick();
        chk("t1_rd_k1", 32'(o_mem_rd), 1);
        chk("t1_addr_k1", 32'(o_mem_addr), 4);
        tick();
        chk("t1_valid_k2", 32'(o_valid), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t1_valid", 32'(o_valid), 1);
            chk("t1_data", 32'(o_data), 32'(8'h14 + i));
            chk("t1_last", 32'(o_last), 32'(i == 4));
            chk("t1_done_early", 32'(o_done), 0);
            tick();
        end
        chk("t1_done", 32'(o_done), 1);
        chk("t1_busy_low", 32'(o_busy), 0);
        chk("t1_valid_low", 32'(o_valid), 0);
        check_words("t1", 4, 5);
        tick();
        chk("t1_done_pulse", 32'(o_done), 0);

        // Same burst with ready toggling then held low: credit stall at 4 outstanding.
        clear_logs();
        i_ready = 1'b0;
        start_burst(6'd4, 7'd5);
        for (int i = 0; i < 4; i++) begin
            i_ready = (i % 2 == 0);
            tick();
        end
        i_ready = 1'b0;
        repeat (10) tick();
        chk("t2_stall_strobes", 32'(strb_addr.size()), 4);
        chk("t2_stall_rd", 32'(o_mem_rd), 0);
        chk("t2_stall_valid", 32'(o_valid), 1);
        chk("t2_stall_head", 32'(o_data), 32'h14);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                i_ready = (i % 2 == 0);
                tick();
                if (o_done) seen = 1'b1;
            end
            chk("t2_done", 32'(seen), 1);
        end
        i_ready = 1'b1;
        check_words("t2", 4, 5);
        chk("t2_strobes", 32'(strb_addr.size()), 5);

        // base=62 len=4 crosses the top of memory.
        clear_logs();
        start_burst(6'd62, 7'd4);
`ifdef MEM_STREAM_READER_WRAP_EN
        chk("t3_err", 32'(o_err), 0);
        wait_done(30, "t3_done");
        chk("t3_strobes", 32'(strb_addr.size()), 4);
        for (int i = 0; i < 4 && i < strb_addr.size(); i++)
            chk("t3_addr", 32'(strb_addr[i]), 32'(6'((62 + i) % 64)));
        check_words("t3", 62, 4);
`else
        chk("t3_err", 32'(o_err), 1);
        chk("t3_busy", 32'(o_busy), 0);
        tick();
        chk("t3_err_pulse", 32'(o_err), 0);
        repeat (4) tick();
        chk("t3_strobes", 32'(strb_addr.size()), 0);
        chk("t3_valid", 32'(o_valid), 0);
`endif

        // len=0: immediate done, no reads.
        clear_logs();
        start_burst(6'd10, 7'd0);
        chk("t4_done", 32'(o_done), 1);
        chk("t4_busy", 32'(o_busy), 0);
        repeat (3) tick();
        chk("t4_strobes", 32'(strb_addr.size()), 0);
        chk("t4_words", 32'(hs_data.size()), 0);

        // Async reset after two words of an 8-word burst, then a clean 2-word burst.
        clear_logs();
        start_burst(6'd0, 7'd8);
        for (int i = 0; i < 20 && hs_data.size() < 2; i++) tick();
        chk("t5_two_words", 32'(hs_data.size()), 2);
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(o_busy), 0);
        chk("t5_rst_valid", 32'(o_valid), 0);
        chk("t5_rst_rd", 32'(o_mem_rd), 0);
        chk("t5_rst_data_addr", 32'({o_data, 2'b00, o_mem_addr}), 0);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        begin
            int extra = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                extra += int'(o_done) + int'(o_valid);
            end
            chk("t5_no_residue", 32'(extra), 0);
        end
        clear_logs();
        start_burst(6'd0, 7'd2);
        wait_done(20, "t5_done");
        check_words("t5", 0, 2);

        // i_start pulsed mid-burst must be ignored.
        clear_logs();
        start_burst(6'd4, 7'd5);
        tick();
        tick();
        start_burst(6'd20, 7'd3);
        wait_done(30, "t6_done");
        check_words("t6", 4, 5);
        repeat (3) tick();
        chk("t6_strobes", 32'(strb_addr.size()), 5);
        chk("t6_busy", 32'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
